// File: rtl/spi_pkg.sv
// Shared definitions for the SPI receive path: state encoding, default widths
// and the saturating word-count helper.
package spi_pkg;

  localparam int unsigned SPI_WORD_WIDTH = 8;
  localparam int unsigned FRAME_BYTES_W  = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } spi_state_e;

  function automatic logic [FRAME_BYTES_W-1:0] sat_inc(input logic [FRAME_BYTES_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/spi_rx_holding_reg.sv
// Output holding register for received words: valid/ready handshake towards
// the consumer plus the sticky overrun flag.
module spi_rx_holding_reg
  import spi_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = SPI_WORD_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_capture,
  input  logic [WORD_WIDTH-1:0] i_data,
  input  logic                  i_ready,
  input  logic                  i_ovr_clr,
  output logic [WORD_WIDTH-1:0] o_data,
  output logic                  o_valid,
  output logic                  o_overrun
);

  logic [WORD_WIDTH-1:0] r_data;
  logic                  r_valid;
  logic                  r_overrun;
  logic                  w_xfer;
  logic                  w_store;
  logic                  w_drop;

  assign w_xfer  = r_valid & i_ready;
  // A slot freed by a transfer on the same edge can take the new word.
  assign w_store = i_capture & (~r_valid | w_xfer);
  assign w_drop  = i_capture & r_valid & ~i_ready;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (w_store) begin
        r_data  <= i_data;
        r_valid <= 1'b1;
      end else if (w_xfer) begin
        r_valid <= 1'b0;
      end

      if (w_drop) begin
        r_overrun <= 1'b1;
      end else if (i_ovr_clr) begin
        r_overrun <= 1'b0;
      end
    end
  end

  assign o_data    = r_data;
  assign o_valid   = r_valid;
  assign o_overrun = r_overrun;

endmodule

// File: rtl/spi_rx_controller.sv
// SPI receive sequencer: frames bits with cs_n, drives the shift register
// load, counts bits and hands completed words to the holding register.
module spi_rx_controller
  import spi_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = SPI_WORD_WIDTH,
  parameter int unsigned CNT_WIDTH  = 3
) (
  input  logic                     spi_clk,
  input  logic                     reset,
  input  logic                     cs_n,
  output logic                     sr_load,
  input  logic [WORD_WIDTH-1:0]    sr_data,
  output logic [WORD_WIDTH-1:0]    rx_data,
  output logic                     rx_valid,
  input  logic                     rx_ready,
  output logic                     overrun,
  input  logic                     overrun_clr,
  output logic                     frame_err,
  output logic                     frame_done,
  output logic [FRAME_BYTES_W-1:0] frame_bytes
);

  spi_state_e               r_state;
  spi_state_e               w_state_nxt;
  logic [CNT_WIDTH-1:0]     r_bit_cnt;
  logic                     r_cap_pending;
  logic                     r_frame_err;
  logic                     r_frame_done;
  logic [FRAME_BYTES_W-1:0] r_frame_bytes;
  logic                     w_shift;
  logic                     w_frame_start;
  logic                     w_frame_end;
  logic                     w_word_end;

  always_comb begin
    w_state_nxt   = r_state;
    w_shift       = 1'b0;
    w_frame_start = 1'b0;
    w_frame_end   = 1'b0;
    case (r_state)
      IDLE: begin
        if (!cs_n) begin
          w_state_nxt   = SHIFT;
          w_frame_start = 1'b1;
        end
      end
      SHIFT: begin
        if (cs_n) begin
          w_state_nxt = IDLE;
          w_frame_end = 1'b1;
        end else begin
          w_shift = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_word_end = w_shift && (r_bit_cnt == CNT_WIDTH'(WORD_WIDTH - 1));
  assign sr_load    = w_shift;

  always_ff @(posedge spi_clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Capture lags the last shift by one edge so sr_data holds the full word.
  always_ff @(posedge spi_clk or posedge reset) begin
    if (reset) begin
      r_bit_cnt     <= '0;
      r_cap_pending <= 1'b0;
      r_frame_err   <= 1'b0;
      r_frame_done  <= 1'b0;
      r_frame_bytes <= '0;
    end else begin
      r_frame_done  <= w_frame_end;
      r_cap_pending <= w_word_end;

      if (w_frame_start || w_frame_end || w_word_end) begin
        r_bit_cnt <= '0;
      end else if (w_shift) begin
        r_bit_cnt <= r_bit_cnt + 1'b1;
      end

      if (w_frame_start) begin
        r_frame_bytes <= '0;
      end else if (r_cap_pending) begin
        r_frame_bytes <= sat_inc(r_frame_bytes);
      end

      if (w_frame_end && (r_bit_cnt != '0)) begin
        r_frame_err <= 1'b1;
      end else if (overrun_clr) begin
        r_frame_err <= 1'b0;
      end
    end
  end

  spi_rx_holding_reg #(
    .WORD_WIDTH(WORD_WIDTH)
  ) u_hold (
    .i_clk     (spi_clk),
    .i_rst     (reset),
    .i_capture (r_cap_pending),
    .i_data    (sr_data),
    .i_ready   (rx_ready),
    .i_ovr_clr (overrun_clr),
    .o_data    (rx_data),
    .o_valid   (rx_valid),
    .o_overrun (overrun)
  );

  assign frame_err   = r_frame_err;
  assign frame_done  = r_frame_done;
  assign frame_bytes = r_frame_bytes;

endmodule

// File: tb/tb_spi_rx_controller.sv
// Scenario bench for spi_rx_controller with a behavioural MSB-first shift
// register and a queue scoreboard checked at each consumer transfer.
module tb_spi_rx_controller;

  logic       spi_clk = 1'b0;
  logic       reset = 1'b1;
  logic       cs_n = 1'b1;
  logic       sdi = 1'b0;
  logic       rx_ready = 1'b1;
  logic       overrun_clr = 1'b0;
  logic       sr_load;
  logic [7:0] sr_data;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       overrun;
  logic       frame_err;
  logic       frame_done;
  logic [7:0] frame_bytes;

  int         compared = 0;
  int         mismatched = 0;
  int         load_cnt = 0;
  int         xfer_cnt = 0;
  int         cycle = 0;
  logic [7:0] exp_q[$];
  int         xfer_cyc[$];

  spi_rx_controller #(
    .WORD_WIDTH(8),
    .CNT_WIDTH (3)
  ) dut (
    .spi_clk     (spi_clk),
    .reset       (reset),
    .cs_n        (cs_n),
    .sr_load     (sr_load),
    .sr_data     (sr_data),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .overrun     (overrun),
    .overrun_clr (overrun_clr),
    .frame_err   (frame_err),
    .frame_done  (frame_done),
    .frame_bytes (frame_bytes)
  );

  always #5 spi_clk = ~spi_clk;

  always @(posedge spi_clk) cycle++;

  always @(posedge spi_clk or posedge reset) begin
    if (reset) sr_data <= '0;
    else if (sr_load) sr_data <= {sr_data[6:0], sdi};
  end

  always @(negedge spi_clk) begin
    logic [7:0] exp;
    if (!reset) begin
      if (sr_load) load_cnt++;
      if (rx_valid && rx_ready) begin
        xfer_cnt++;
        xfer_cyc.push_back(cycle);
        compared++;
        if (exp_q.size() == 0) begin
          mismatched++;
          $display("FAIL scoreboard: unexpected word rx_data=%h, none expected", rx_data);
        end else begin
          exp = exp_q.pop_front();
          if (rx_data !== exp) begin
            mismatched++;
            $display("FAIL scoreboard: rx_data=%h expected %h", rx_data, exp);
          end
        end
      end
    end
  end

  task automatic tick;
    @(posedge spi_clk);
    #1;
  endtask

  task automatic start_frame;
    cs_n = 1'b0;
    tick();
  endtask

  task automatic send_word(input logic [7:0] w, input bit expect_it);
    if (expect_it) exp_q.push_back(w);
    for (int i = 7; i >= 0; i--) begin
      sdi = w[i];
      tick();
    end
  endtask

  task automatic end_frame;
    cs_n = 1'b1;
    tick();
  endtask

  task automatic drain(input string name);
    for (int n = 0; n < 20 && exp_q.size() != 0; n++) tick();
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL %s drain: %0d words still pending, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    cs_n  = 1'b1;
    repeat (5) tick();
    compared++;
    if ({rx_data, rx_valid, overrun, frame_err, frame_done, frame_bytes, sr_load} !== '0) begin
      mismatched++;
      $display("FAIL reset: outputs=%h expected 0",
               {rx_data, rx_valid, overrun, frame_err, frame_done, frame_bytes, sr_load});
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic;
    rx_ready = 1'b1;
    load_cnt = 0;
    xfer_cnt = 0;
    start_frame();
    send_word(8'h69, 1'b1);
    end_frame();
    compared++;
    if (frame_done !== 1'b1) begin
      mismatched++;
      $display("FAIL basic frame_done: got %b expected 1", frame_done);
    end
    compared++;
    if (frame_bytes !== 8'd1) begin
      mismatched++;
      $display("FAIL basic frame_bytes: got %0d expected 1", frame_bytes);
    end
    tick();
    compared++;
    if (frame_done !== 1'b0) begin
      mismatched++;
      $display("FAIL basic frame_done pulse width: got %b expected 0", frame_done);
    end
    drain("basic");
    repeat (3) tick();
    compared++;
    if (load_cnt != 8) begin
      mismatched++;
      $display("FAIL basic sr_load cycles: got %0d expected 8", load_cnt);
    end
    compared++;
    if (xfer_cnt != 1) begin
      mismatched++;
      $display("FAIL basic rx_valid pulses: got %0d expected 1", xfer_cnt);
    end
  endtask

  task automatic test_back_to_back;
    rx_ready = 1'b1;
    xfer_cyc.delete();
    start_frame();
    send_word(8'h69, 1'b1);
    send_word(8'hA5, 1'b1);
    end_frame();
    drain("b2b");
    tick();
    compared++;
    if (xfer_cyc.size() != 2) begin
      mismatched++;
      $display("FAIL b2b transfers: got %0d expected 2", xfer_cyc.size());
    end else begin
      compared++;
      if (xfer_cyc[1] - xfer_cyc[0] != 8) begin
        mismatched++;
        $display("FAIL b2b spacing: got %0d cycles expected 8", xfer_cyc[1] - xfer_cyc[0]);
      end
    end
    compared++;
    if (overrun !== 1'b0 || frame_bytes !== 8'd2) begin
      mismatched++;
      $display("FAIL b2b status: overrun=%b frame_bytes=%0d expected 0/2", overrun, frame_bytes);
    end
  endtask

  task automatic test_overrun;
    rx_ready = 1'b0;
    start_frame();
    send_word(8'h69, 1'b1);
    send_word(8'hA5, 1'b0);
    end_frame();
    compared++;
    if (rx_data !== 8'h69 || rx_valid !== 1'b1) begin
      mismatched++;
      $display("FAIL overrun hold: rx_data=%h rx_valid=%b expected 69/1", rx_data, rx_valid);
    end
    compared++;
    if (overrun !== 1'b1) begin
      mismatched++;
      $display("FAIL overrun flag: got %b expected 1", overrun);
    end
    compared++;
    if (frame_bytes !== 8'd2) begin
      mismatched++;
      $display("FAIL overrun frame_bytes: got %0d expected 2", frame_bytes);
    end
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    compared++;
    if (overrun !== 1'b0 || rx_valid !== 1'b1 || rx_data !== 8'h69) begin
      mismatched++;
      $display("FAIL overrun clear: overrun=%b rx_valid=%b rx_data=%h expected 0/1/69",
               overrun, rx_valid, rx_data);
    end
    rx_ready = 1'b1;
    drain("overrun");
  endtask

  task automatic test_frame_err;
    rx_ready = 1'b1;
    xfer_cnt = 0;
    start_frame();
    for (int i = 0; i < 5; i++) begin
      sdi = 1'b1;
      tick();
    end
    end_frame();
    compared++;
    if (frame_err !== 1'b1 || frame_done !== 1'b1) begin
      mismatched++;
      $display("FAIL frame_err flags: frame_err=%b frame_done=%b expected 1/1", frame_err, frame_done);
    end
    compared++;
    if (frame_bytes !== 8'd0) begin
      mismatched++;
      $display("FAIL frame_err frame_bytes: got %0d expected 0", frame_bytes);
    end
    repeat (3) tick();
    compared++;
    if (xfer_cnt != 0) begin
      mismatched++;
      $display("FAIL frame_err capture: got %0d transfers expected 0", xfer_cnt);
    end
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    compared++;
    if (frame_err !== 1'b0) begin
      mismatched++;
      $display("FAIL frame_err clear: got %b expected 0", frame_err);
    end
    start_frame();
    send_word(8'h3C, 1'b1);
    end_frame();
    compared++;
    if (frame_bytes !== 8'd1 || frame_err !== 1'b0) begin
      mismatched++;
      $display("FAIL frame_err recovery: frame_bytes=%0d frame_err=%b expected 1/0", frame_bytes, frame_err);
    end
    drain("frame_err");
  endtask

  task automatic test_boundary;
    rx_ready = 1'b1;
    start_frame();
    send_word(8'h81, 1'b1);
    end_frame();
    compared++;
    if (rx_valid !== 1'b1 || rx_data !== 8'h81) begin
      mismatched++;
      $display("FAIL boundary capture: rx_valid=%b rx_data=%h expected 1/81", rx_valid, rx_data);
    end
    compared++;
    if (frame_err !== 1'b0 || frame_done !== 1'b1) begin
      mismatched++;
      $display("FAIL boundary flags: frame_err=%b frame_done=%b expected 0/1", frame_err, frame_done);
    end
    drain("boundary");
    tick();
  endtask

  task automatic test_async_reset;
    rx_ready = 1'b1;
    start_frame();
    send_word(8'hF0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    compared++;
    if ({rx_data, rx_valid, overrun, frame_err, frame_done, frame_bytes} !== '0) begin
      mismatched++;
      $display("FAIL async reset outputs: got %h expected 0",
               {rx_data, rx_valid, overrun, frame_err, frame_done, frame_bytes});
    end
    compared++;
    if (sr_load !== 1'b0) begin
      mismatched++;
      $display("FAIL async reset sr_load: got %b expected 0", sr_load);
    end
    cs_n = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    tick();
    start_frame();
    send_word(8'h69, 1'b1);
    end_frame();
    compared++;
    if (frame_bytes !== 8'd1 || frame_err !== 1'b0) begin
      mismatched++;
      $display("FAIL async reset recovery: frame_bytes=%0d frame_err=%b expected 1/0", frame_bytes, frame_err);
    end
    drain("async_reset");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_overrun();
    test_frame_err();
    test_boundary();
    test_async_reset();
    repeat (2) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
